// File: rtl/fp_instr_feeder.sv
// fp_instr_feeder
//   Issue stage in front of the FP wrapper. Holds a program RAM of 32-bit FP
//   instructions and issues a bounded run of them in order over a valid/ready
//   handshake. Results that come back are stored in a result RAM. Their
//   exception flags are ORed into a sticky error flag.
//
//   Ports
//     clk_i, rst_i           clock, asynchronous active-high reset
//     prog_we_i/addr/data    program RAM write port (accepted only in IDLE)
//     start_i, num_instr_i   run request and instruction count
//     abort_i                abandon the current run (flush pulse, no done)
//     instr_o, in_valid_o,   instruction handshake toward the wrapper
//       in_ready_i
//     result_i, status_i,    result handshake from the wrapper
//       out_valid_i, out_ready_o
//     flush_o                one-cycle flush pulse after an abort
//     res_rd_addr_i/data_o   combinational result RAM read port
//     busy_o, done_o, err_o  run status
//     issued_o, retired_o    run counters
//     cycles_o               busy-cycle counter
//
//   Build option
//     FP_FEEDER_CYCLES_EN    when defined, cycles_o counts busy cycles and
//                            saturates. Otherwise cycles_o is tied to zero.
module fp_instr_feeder #(
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH),
    parameter int MAX_OUT = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [31:0]   prog_data_i,
    input  logic          start_i,
    input  logic [AW:0]   num_instr_i,
    input  logic          abort_i,
    output logic [31:0]   instr_o,
    output logic          in_valid_o,
    input  logic          in_ready_i,
    input  logic [31:0]   result_i,
    input  logic [4:0]    status_i,
    input  logic          out_valid_i,
    output logic          out_ready_o,
    output logic          flush_o,
    input  logic [AW-1:0] res_rd_addr_i,
    output logic [31:0]   res_rd_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   issued_o,
    output logic [AW:0]   retired_o,
    output logic [31:0]   cycles_o
);

    localparam int            OW      = $clog2(MAX_OUT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [31:0]   prog_mem [DEPTH];
    logic [31:0]   res_mem  [DEPTH];
    logic [AW:0]   count, issued, retired;
    logic [AW-1:0] issue_ptr, retire_ptr;
    logic [OW-1:0] outstanding;
    logic          err, flush;
    logic          start_idle, num_ok, abort_ok, issue_fire, retire_fire;

    assign num_ok      = (num_instr_i != '0) && (num_instr_i <= DEPTH_C);
    assign start_idle  = (state == S_IDLE) && start_i;
    assign issue_fire  = in_valid_o & in_ready_i;
    assign retire_fire = out_valid_i & out_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Both handshakes are withheld in the abort cycle. This keeps the
    // counters exactly where they were when the abort was seen.
    always_comb begin
        state_nxt   = state;
        in_valid_o  = 1'b0;
        out_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        abort_ok    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = num_ok ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                busy_o      = 1'b1;
                abort_ok    = abort_i;
                in_valid_o  = !abort_i && (issued < count) && (outstanding < MAX_C);
                out_ready_o = !abort_i && (outstanding != '0);
                if (abort_i)
                    state_nxt = S_IDLE;
                else if (in_valid_o && in_ready_i && (issued + (AW+1)'(1) == count))
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o      = 1'b1;
                abort_ok    = abort_i;
                out_ready_o = !abort_i && (outstanding != '0);
                if (abort_i)                state_nxt = S_IDLE;
                else if (retired == count)  state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count       <= '0;
            issued      <= '0;
            retired     <= '0;
            issue_ptr   <= '0;
            retire_ptr  <= '0;
            outstanding <= '0;
            err         <= 1'b0;
            flush       <= 1'b0;
        end else begin
            flush <= abort_ok;
            if (start_idle) begin
                count       <= num_instr_i;
                issued      <= '0;
                retired     <= '0;
                issue_ptr   <= '0;
                retire_ptr  <= '0;
                outstanding <= '0;
                err         <= 1'b0;
            end else if (abort_ok) begin
                outstanding <= '0;
            end else begin
                if (issue_fire) begin
                    issue_ptr <= issue_ptr + AW'(1);
                    issued    <= issued + (AW+1)'(1);
                end
                if (retire_fire) begin
                    retire_ptr <= retire_ptr + AW'(1);
                    retired    <= retired + (AW+1)'(1);
                    err        <= err | (|status_i);
                end
                if (issue_fire && !retire_fire)
                    outstanding <= outstanding + OW'(1);
                else if (!issue_fire && retire_fire)
                    outstanding <= outstanding - OW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (prog_we_i && (state == S_IDLE)) prog_mem[prog_addr_i] <= prog_data_i;
        if (retire_fire)                    res_mem[retire_ptr]   <= result_i;
    end

    assign instr_o       = (state == S_ISSUE) ? prog_mem[issue_ptr] : '0;
    assign res_rd_data_o = res_mem[res_rd_addr_i];
    assign flush_o       = flush;
    assign err_o         = err;
    assign issued_o      = issued;
    assign retired_o     = retired;

`ifdef FP_FEEDER_CYCLES_EN
    logic [31:0] cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                       cycles <= '0;
        else if (start_idle)             cycles <= '0;
        else if (busy_o && cycles != '1) cycles <= cycles + 32'd1;
    end

    assign cycles_o = cycles;
`else
    assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_fp_instr_feeder.sv
module tb_fp_instr_feeder;

    localparam int DEPTH   = 32;
    localparam int AW      = 5;
    localparam int MAX_OUT = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          prog_we_i, start_i, abort_i, in_ready_i, out_valid_i;
    logic [AW-1:0] prog_addr_i, res_rd_addr_i;
    logic [31:0]   prog_data_i, result_i;
    logic [AW:0]   num_instr_i;
    logic [4:0]    status_i;
    logic [31:0]   instr_o, res_rd_data_o, cycles_o;
    logic          in_valid_o, out_ready_o, flush_o, busy_o, done_o, err_o;
    logic [AW:0]   issued_o, retired_o;

    fp_instr_feeder #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i),
        .start_i(start_i), .num_instr_i(num_instr_i), .abort_i(abort_i),
        .instr_o(instr_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
        .result_i(result_i), .status_i(status_i), .out_valid_i(out_valid_i),
        .out_ready_o(out_ready_o), .flush_o(flush_o),
        .res_rd_addr_i(res_rd_addr_i), .res_rd_data_o(res_rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .issued_o(issued_o), .retired_o(retired_o), .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // mode: 0 ready always, 1 random ready/valid, 2 ready low for 3 valid cycles
    typedef struct {
        int num; int lat; int mode; int err_idx; bit poke;
        int exp_iss; int exp_ret; bit exp_err; int exp_done; int exp_done_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  st;
        int          rdy;
    } pend_t;

    vec_t        vecs [8];
    logic [31:0] prog_ref [DEPTH];
    pend_t       pend [$];

    // Wrapper behaviour: the result is a fixed scramble of the instruction.
    function automatic logic [31:0] res_of(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        prog_we_i = 1'b0; prog_addr_i = '0; prog_data_i = '0;
        start_i = 1'b0; num_instr_i = '0; abort_i = 1'b0;
        in_ready_i = 1'b0; out_valid_i = 1'b0; result_i = '0; status_i = '0;
        res_rd_addr_i = '0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"},    32'(busy_o),      0);
        chk({tag, "_valid"},   32'(in_valid_o),  0);
        chk({tag, "_oready"},  32'(out_ready_o), 0);
        chk({tag, "_flush"},   32'(flush_o),     0);
        chk({tag, "_done"},    32'(done_o),      0);
        chk({tag, "_err"},     32'(err_o),       0);
        chk({tag, "_issued"},  32'(issued_o),    0);
        chk({tag, "_retired"}, 32'(retired_o),   0);
        chk({tag, "_cycles"},  cycles_o,         0);
        chk({tag, "_instr"},   instr_o,          0);
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            prog_ref[i] = $urandom;
            prog_we_i   = 1'b1;
            prog_addr_i = AW'(i);
            prog_data_i = prog_ref[i];
        end
        @(negedge clk_i);
        prog_we_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int num_eff, iss, ret, outm, cyc, post, done_cnt, first_done, busy_cnt, stall_cnt;
        int instr_bad, stab_bad, flow_bad, cnt_bad;
        logic err_m, vs, rs, ors, bs, ds, prev_v, prev_r, held, ifire, rfire;
        logic [31:0] ins, prev_ins;
        pend_t p;
        num_eff = (v.num >= 1 && v.num <= DEPTH) ? v.num : 0;
        if (num_eff > 0) load(num_eff);
        pend.delete();
        iss = 0; ret = 0; outm = 0; cyc = 0; post = 0; done_cnt = 0; first_done = -1;
        busy_cnt = 0; stall_cnt = 0; instr_bad = 0; stab_bad = 0; flow_bad = 0; cnt_bad = 0;
        err_m = 1'b0; prev_v = 1'b0; prev_r = 1'b0; held = 1'b0; prev_ins = '0;
        @(negedge clk_i);
        start_i     = 1'b1;
        num_instr_i = (AW+1)'(v.num);
        while (cyc < 400 && !(done_cnt > 0 && post >= 3)) begin
            @(negedge clk_i);
            start_i   = 1'b0;
            prog_we_i = 1'b0;
            if (v.poke && cyc == 3) begin
                start_i     = 1'b1;
                num_instr_i = (AW+1)'(2);
                prog_we_i   = 1'b1;
                prog_addr_i = AW'(num_eff - 1);
                prog_data_i = ~prog_ref[num_eff - 1];
            end
            case (v.mode)
                0:       in_ready_i = 1'b1;
                1:       in_ready_i = ($urandom_range(0, 2) != 0);
                default: in_ready_i = (stall_cnt >= 3);
            endcase
            if (pend.size() > 0 && pend[0].rdy <= cyc &&
                (held || v.mode != 1 || $urandom_range(0, 3) != 0)) begin
                out_valid_i = 1'b1;
                result_i    = pend[0].res;
                status_i    = pend[0].st;
            end else begin
                out_valid_i = 1'b0;
                result_i    = $urandom;
                status_i    = 5'h1f;
            end
            #1;
            vs = in_valid_o; rs = in_ready_i; ins = instr_o;
            ors = out_ready_o; bs = busy_o; ds = done_o;
            if (vs && ins !== prog_ref[AW'(iss % DEPTH)]) instr_bad++;
            if (prev_v && !prev_r && (!vs || ins !== prev_ins)) stab_bad++;
            if (vs && (iss >= num_eff || outm >= MAX_OUT)) flow_bad++;
            if (!vs && bs && iss < num_eff && outm < MAX_OUT) flow_bad++;
            if (ors !== (bs && outm > 0)) flow_bad++;
            if (issued_o !== (AW+1)'(iss) || retired_o !== (AW+1)'(ret) || err_o !== err_m)
                cnt_bad++;
            if (bs) busy_cnt++;
            if (ds) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end else if (done_cnt > 0) begin
                post++;
            end
            if (vs && !rs) stall_cnt++;
            ifire = vs && rs;
            rfire = out_valid_i && ors;
            held  = out_valid_i && !ors;
            prev_v = vs; prev_r = rs; prev_ins = ins;
            @(posedge clk_i);
            if (rfire) begin
                err_m = err_m | (|pend[0].st);
                void'(pend.pop_front());
                ret++;
            end
            if (ifire) begin
                p.res = res_of(prog_ref[AW'(iss % DEPTH)]);
                p.st  = (iss == v.err_idx) ? 5'b00001 : 5'b00000;
                p.rdy = cyc + v.lat;
                pend.push_back(p);
                iss++;
            end
            outm = iss - ret;
            cyc++;
        end
        @(negedge clk_i);
        idle_inputs();
        #1;
        chk("issued",    32'(issued_o),  32'(v.exp_iss));
        chk("retired",   32'(retired_o), 32'(v.exp_ret));
        chk("err",       32'(err_o),     32'(v.exp_err));
        chk("done_cnt",  32'(done_cnt),  32'(v.exp_done));
        chk("busy_end",  32'(busy_o),    0);
        chk("instr_seq", 32'(instr_bad), 0);
        chk("stable",    32'(stab_bad),  0);
        chk("flow",      32'(flow_bad),  0);
        chk("counters",  32'(cnt_bad),   0);
        if (v.exp_done_cyc >= 0) chk("done_lat", 32'(first_done), 32'(v.exp_done_cyc));
        if (v.mode == 2)         chk("stall_cyc", 32'(stall_cnt), 3);
`ifdef FP_FEEDER_CYCLES_EN
        chk("cycles", cycles_o, 32'(busy_cnt));
`else
        chk("cycles", cycles_o, 0);
`endif
        for (int i = 0; i < num_eff; i++) begin
            @(negedge clk_i);
            res_rd_addr_i = AW'(i);
            #1;
            chk($sformatf("res[%0d]", i), res_rd_data_o, res_of(prog_ref[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        int fires, done_seen;
        //          num lat mode eidx poke  iss ret err done dcyc
        vecs[0] = '{4,  2,  0,   -1,  0,    4,  4,  0,  1,   -1};
        vecs[1] = '{8,  1,  1,    3,  1,    8,  8,  1,  1,   -1};
        vecs[2] = '{0,  1,  0,   -1,  0,    0,  0,  0,  1,    0};
        vecs[3] = '{32, 5,  1,   -1,  0,   32, 32,  0,  1,   -1};
        vecs[4] = '{33, 1,  0,   -1,  0,    0,  0,  0,  1,    0};
        vecs[5] = '{3,  2,  2,   -1,  0,    3,  3,  0,  1,   -1};
        vecs[6] = '{1,  1,  0,   -1,  0,    1,  1,  0,  1,   -1};
        vecs[7] = '{6,  3,  1,    5,  0,    6,  6,  1,  1,   -1};

        idle_inputs();
        #2 rst_i = 1'b1;
        #1 chk_zero_outputs("rst");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Wrapper never answers: issue stops at MAX_OUT, then abort.
        load(10);
        @(negedge clk_i);
        start_i = 1'b1; num_instr_i = (AW+1)'(10);
        fires = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            start_i = 1'b0; in_ready_i = 1'b1; out_valid_i = 1'b0;
            #1;
            if (in_valid_o && in_ready_i) fires++;
        end
        chk("maxout_fires",  32'(fires),      MAX_OUT);
        chk("maxout_issued", 32'(issued_o),   MAX_OUT);
        chk("maxout_valid",  32'(in_valid_o), 0);
        chk("maxout_busy",   32'(busy_o),     1);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("abort_flush",  32'(flush_o),    1);
        chk("abort_busy",   32'(busy_o),     0);
        chk("abort_valid",  32'(in_valid_o), 0);
        chk("abort_issued", 32'(issued_o),   MAX_OUT);
        @(negedge clk_i);
        abort_i = 1'b0; out_valid_i = 1'b1; result_i = 32'hDEAD_BEEF; status_i = 5'h1f;
        #1;
        chk("idle_oready", 32'(out_ready_o), 0);
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 0) chk("flush_once", 32'(flush_o), 0);
            if (done_o) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 0);
        chk("abort_retired", 32'(retired_o), 0);
        chk("abort_err",     32'(err_o),     0);
        idle_inputs();
        run_vec(vecs[0]);

        // Reset in the middle of a run.
        load(8);
        @(negedge clk_i);
        start_i = 1'b1; num_instr_i = (AW+1)'(8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            start_i = 1'b0; in_ready_i = 1'b1; out_valid_i = 1'b0;
        end
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk_zero_outputs("midrst");
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) done_seen++;
        end
        chk("midrst_quiet", 32'(done_seen), 0);
        run_vec(vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
